// File: rtl/tt_um_result_tx.sv
// tt_um_result_tx: captures accumulator results and streams them as a framed 16-bit word sequence
// Ports: clk, rst_n (async active-low); start captures ui_results/ui_param and begins a frame;
//   ui_hold stalls the current word; uo_data/uo_valid carry header then N results;
//   uo_busy is high during header/data; uo_done pulses once after the last word transfers.
module tt_um_result_tx #(
  parameter int MAX_OUT_LEN = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [6:0]                       ui_param,
  input  logic [MAX_OUT_LEN*ACC_WIDTH-1:0] ui_results,
  input  logic                             ui_hold,
  output logic [15:0]                      uo_data,
  output logic                             uo_valid,
  output logic                             uo_busy,
  output logic                             uo_done
);
  localparam int CW = MAX_OUT_LEN > 1 ? $clog2(MAX_OUT_LEN) : 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt, last;
  logic [ACC_WIDTH-1:0] buf_q [MAX_OUT_LEN];
  logic xfer;
  assign xfer = uo_valid & ~ui_hold;
  function automatic logic [15:0] sext(input logic [ACC_WIDTH-1:0] v);
    return 16'($signed(v));
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      uo_data <= '0;
      uo_valid <= 1'b0;
      uo_busy <= 1'b0;
      uo_done <= 1'b0;
      cnt <= '0;
      last <= '0;
      for (int i = 0; i < MAX_OUT_LEN; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          uo_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < MAX_OUT_LEN; i++) buf_q[i] <= ui_results[i*ACC_WIDTH +: ACC_WIDTH];
            // last word index = min(out_len, MAX_OUT_LEN) - 1
            last <= (int'(ui_param[2:0]) >= MAX_OUT_LEN - 1) ? CW'(MAX_OUT_LEN - 1) : CW'(ui_param[2:0]);
            cnt <= '0;
            uo_data <= {4'h5, 5'b0, ui_param};
            uo_valid <= 1'b1;
            uo_busy <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            uo_data <= sext(buf_q[0]);
            state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (cnt == last) begin
              uo_data <= '0;
              uo_valid <= 1'b0;
              uo_busy <= 1'b0;
              uo_done <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
              uo_data <= sext(buf_q[cnt + 1'b1]);
            end
          end
        end
        DONE: begin
          uo_done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_um_result_tx.sv
// tb_tt_um_result_tx: directed checks of framing, stall, ignored start, sign extension and reset
module tb_tt_um_result_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start8 = 1'b0;
  logic hold = 1'b0;
  logic [6:0] param = '0;
  logic [127:0] res = '0;
  logic [63:0] res8 = '0;
  logic [15:0] data, data8;
  logic valid, busy, done, valid8, busy8, done8;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_full [8] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

  tt_um_result_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ui_param(param), .ui_results(res),
    .ui_hold(hold), .uo_data(data), .uo_valid(valid), .uo_busy(busy), .uo_done(done)
  );

  tt_um_result_tx #(.MAX_OUT_LEN(8), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ui_param(param), .ui_results(res8),
    .ui_hold(hold), .uo_data(data8), .uo_valid(valid8), .uo_busy(busy8), .uo_done(done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input string tag, input logic [15:0] w);
    chk({tag, "_data"}, data, w);
    chk({tag, "_flags"}, {13'b0, valid, busy, done}, 16'b110);
  endtask

  task automatic done_state(input string tag);
    chk({tag, "_done"}, {data[14:0], valid, busy, done} , 18'b001);
  endtask

  initial begin
    #2;
    chk("reset_flags", {13'b0, valid, busy, done}, 16'b0);
    chk("reset_data", data, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_flags", {13'b0, valid, busy, done}, 16'b0);

    // full frame: slot k = k-4
    for (int k = 0; k < 8; k++) res[k*16 +: 16] = 16'(k - 4);
    param = 7'h07;
    start = 1'b1;
    tick();
    start = 1'b0;
    word("full_hdr", 16'h5007);
    for (int k = 0; k < 8; k++) begin
      tick();
      word($sformatf("full_w%0d", k), exp_full[k]);
    end
    tick();
    done_state("full");
    tick();
    chk("full_after", {13'b0, valid, busy, done}, 16'b0);

    // short frame with start and hold together in IDLE, plus ignored starts in DATA and DONE
    res = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h7FFF, 16'h8000, 16'h1234};
    param = 7'h12;
    start = 1'b1;
    hold = 1'b1;
    tick();
    start = 1'b0;
    word("short_hdr", 16'h5012);
    tick();
    word("short_hdr_hold", 16'h5012);
    hold = 1'b0;
    tick();
    word("short_w0", 16'h1234);
    start = 1'b1;
    param = 7'h07;
    res = {8{16'hAAAA}};
    tick();
    start = 1'b0;
    word("short_w1", 16'h8000);
    tick();
    word("short_w2", 16'h7FFF);
    tick();
    done_state("short");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("short_idle", {13'b0, valid, busy, done}, 16'b0);
    tick();
    chk("short_no_second", {13'b0, valid, busy, done}, 16'b0);

    // stall on word FFFE for 3 cycles
    for (int k = 0; k < 8; k++) res[k*16 +: 16] = 16'(k - 4);
    param = 7'h07;
    start = 1'b1;
    tick();
    start = 1'b0;
    word("stall_hdr", 16'h5007);
    tick();
    word("stall_w0", 16'hFFFC);
    tick();
    word("stall_w1", 16'hFFFD);
    tick();
    word("stall_w2", 16'hFFFE);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      word($sformatf("stall_hold%0d", i), 16'hFFFE);
    end
    hold = 1'b0;
    for (int k = 3; k < 8; k++) begin
      tick();
      word($sformatf("stall_w%0d", k), exp_full[k]);
    end
    tick();
    done_state("stall");
    tick();

    // 8-bit sign extension
    res8 = '0;
    res8[7:0] = 8'h80;
    res8[15:8] = 8'h7F;
    res8[23:16] = 8'h55;
    param = 7'h01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("sx_hdr", data8, 16'h5001);
    tick();
    chk("sx_w0", data8, 16'hFF80);
    tick();
    chk("sx_w1", data8, 16'h007F);
    tick();
    chk("sx_done", {13'b0, valid8, busy8, done8}, 16'b001);
    chk("sx_idle_main", {13'b0, valid, busy, done}, 16'b0);
    tick();

    // reset mid-frame during word 2
    param = 7'h07;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    word("rst_w2", 16'hFFFE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_flags", {13'b0, valid, busy, done}, 16'b0);
    chk("rst_data", data, 16'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_after%0d", i), {13'b0, valid, busy, done}, 16'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_result_tx.md
Name: tt_um_result_tx

Overview:
Transmit side of the 16-bit pin-level word protocol that the load path receives on. After a multiply completes, this block captures the MAX_OUT_LEN signed accumulator results into a shadow buffer. It then streams them off-chip as a framed sequence: one header word, N result words, then a one-cycle done pulse. At the top level it drives {uo_out, uio_out} (uio_oe all ones while busy). The host can stall the stream with a hold pin.

Parameters:
MAX_OUT_LEN, 8, number of result slots in the buffer (power of 2, max 8)
ACC_WIDTH, 16, width of each signed result (must be ≤16)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to capture results and send a frame
ui_param  input  7  frame config; [2:0] = out_len-1; copied verbatim into the header
ui_results  input  MAX_OUT_LEN*ACC_WIDTH  packed results, slot k at [k*ACC_WIDTH +: ACC_WIDTH]
ui_hold  input  1  host stall; high = do not consume the current word
uo_data  output  16  current word on the bus
uo_valid  output  1  uo_data holds a frame word
uo_busy  output  1  frame in progress (HDR or DATA state)
uo_done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; uo_data=0, uo_valid=0, uo_busy=0, uo_done=0.
  - Word counter and buffer cleared.
  - Takes effect immediately, including mid-frame; no partial-frame completion or done pulse.
- All outputs are registered.
- Transfer rule: a word is consumed at a rising edge where uo_valid=1 and ui_hold=0. With ui_hold=1, state, counter, uo_data and uo_valid hold unchanged.
- Frame length: N = min(ui_param[2:0]+1, MAX_OUT_LEN). N is latched at start.
- States:
  - IDLE:
    - uo_valid=0, uo_data=0.
    - start=1 at edge E0: latch ui_results into the buffer, latch N, counter=0.
    - Drive uo_data={4'h5, 5'b0, ui_param}, uo_valid=1, uo_busy=1, then go to HDR.
    - ui_hold is ignored in IDLE.
  - HDR: on transfer, uo_data=sign-extend(buffer[0]) to 16 bits, go to DATA.
  - DATA:
    - On transfer with counter<N-1: counter+1, uo_data=sign-extend(buffer[counter+1]).
    - On transfer with counter=N-1: uo_valid=0, uo_data=0, uo_busy=0, uo_done=1, go to DONE.
  - DONE: uo_done returns to 0 next edge, go to IDLE. A start seen in DONE is ignored.
- Latency with hold low: header valid the cycle after E0; word k valid at E0+2+k; done at E0+N+2.
- start while busy or in DONE: ignored. Buffer and N stay unchanged; ui_results changes after capture have no effect.
- Simultaneous start and ui_hold in IDLE: start wins, header is presented.
- Unused upper results slots (k≥N) are never emitted.

Test Plan:
- Reset values: assert rst_n=0 mid-frame (during word 2 of 8) → same cycle uo_valid=0, uo_busy=0, uo_data=0; after release, IDLE with no done pulse.
- Full frame: ui_param=7'h07, results slot k = k-4 (−4..3), hold=0, start at E0 → header 16'h5007 at E0+1, then 16'hFFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003, then uo_done=1 for exactly one cycle at E0+10.
- Short frame: ui_param=7'h12 (N=3), slots 16'h1234, 16'h8000, 16'h7FFF → header 16'h5012, then 1234, 8000, 7FFF, then done; slots 3..7 never appear.
- Stall: same as the full frame but hold=1 for 3 cycles while word 16'hFFFE is valid → that word persists 4 cycles and the remaining sequence is unchanged; done is delayed by 3 cycles.
- Ignored start: pulse start with different ui_results/ui_param during DATA and during DONE → frame contents unchanged, no second frame.
- Sign extension: ACC_WIDTH=8, slot0=8'h80, slot1=8'h7F, ui_param=7'h01 → words 16'hFF80, 16'h007F.
